// File: rtl/money_pkg.sv
// Shared types, coin codes and helpers for the BCD credit accumulator.
package money_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [2:0] COIN_5       = 3'b000;
  localparam logic [2:0] COIN_10      = 3'b001;
  localparam logic [2:0] COIN_15      = 3'b010;
  localparam logic [2:0] COIN_20      = 3'b011;
  localparam logic [2:0] COIN_50      = 3'b100;
  localparam logic [2:0] COIN_100     = 3'b101;
  localparam logic [2:0] COIN_200     = 3'b110;
  localparam logic [2:0] COIN_INVALID = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD    = 2'd1,
    ST_SUB    = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Denomination code to BCD addend; digits above the credit width are cleared.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] coin_to_bcd(input logic [2:0] code,
                                                              input int unsigned digits);
    logic [BCD_W*MAX_DIGITS-1:0] v;
    case (code)
      COIN_5:   v = 32'h0000_0005;
      COIN_10:  v = 32'h0000_0010;
      COIN_15:  v = 32'h0000_0015;
      COIN_20:  v = 32'h0000_0020;
      COIN_50:  v = 32'h0000_0050;
      COIN_100: v = 32'h0000_0100;
      COIN_200: v = 32'h0000_0200;
      default:  v = '0;
    endcase
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i >= digits) v[i*BCD_W +: BCD_W] = 4'h0;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit adder/subtractor with decimal carry/borrow.
module bcd_digit_addsub
  import money_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [BCD_W-1:0] digit,
  output logic             cout
);

  logic [4:0] sum;
  logic [4:0] diff;

  // Binary result then decimal correction: +6 past 9 on add, +10 when negative on subtract.
  always_comb begin
    sum   = 5'(a) + 5'(b) + 5'(cin);
    diff  = 5'(a) - 5'(b) - 5'(cin);
    digit = sum[3:0];
    cout  = 1'b0;
    if (sub) begin
      if (diff[4]) begin
        digit = 4'(diff + 5'd10);
        cout  = 1'b1;
      end else begin
        digit = diff[3:0];
      end
    end else if (sum > 5'd9) begin
      digit = 4'(sum + 5'd6);
      cout  = 1'b1;
    end
  end

endmodule

// File: rtl/money_accumulator_bcd.sv
// BCD credit register: coins and purchases are applied one digit per cycle
// through a shared slice and committed only when the result is legal.
module money_accumulator_bcd
  import money_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned COIN_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COIN_W-1:0]       coin,
  input  logic                    coin_valid,
  input  logic [BCD_W*DIGITS-1:0] price,
  input  logic                    buy_valid,
  input  logic                    clear,
  output logic                    ready,
  output logic [BCD_W*DIGITS-1:0] total,
  output logic                    coin_accept,
  output logic                    coin_reject,
  output logic                    buy_ok,
  output logic                    buy_fail
);

  localparam int unsigned W     = BCD_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     work;
  logic [W-1:0]     operand;

  logic [BCD_W-1:0] a_dig;
  logic [BCD_W-1:0] b_dig;
  logic [BCD_W-1:0] res_dig;
  logic             res_cout;
  logic             is_sub;
  logic [W-1:0]     work_next;
  logic [W-1:0]     addend;
  logic             coin_bad;
  logic             price_bad;

  // Select the current digit pair and merge the slice result back into the work value.
  always_comb begin
    a_dig     = work[idx*BCD_W +: BCD_W];
    b_dig     = operand[idx*BCD_W +: BCD_W];
    is_sub    = (state == ST_SUB);
    work_next = work;
    work_next[idx*BCD_W +: BCD_W] = res_dig;
  end

  // Decode strobe qualifiers: invalid coin code and non-BCD price digits.
  always_comb begin
    addend    = W'(coin_to_bcd(coin[2:0], DIGITS));
    coin_bad  = (coin >= COIN_W'(7));
    price_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (price[i*BCD_W +: BCD_W] > 4'd9) price_bad = 1'b1;
    end
  end

  bcd_digit_addsub u_slice (
    .a     (a_dig),
    .b     (b_dig),
    .cin   (carry),
    .sub   (is_sub),
    .digit (res_dig),
    .cout  (res_cout)
  );

  // Control FSM; the result pulse and total update are launched on the last digit
  // edge so both are visible during the COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      work        <= '0;
      operand     <= '0;
      total       <= '0;
      ready       <= 1'b1;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      buy_ok      <= 1'b0;
      buy_fail    <= 1'b0;
    end else begin
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      buy_ok      <= 1'b0;
      buy_fail    <= 1'b0;
      if (clear) begin
        state <= ST_IDLE;
        idx   <= '0;
        carry <= 1'b0;
        total <= '0;
        ready <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (coin_valid) begin
              if (coin_bad) begin
                coin_reject <= 1'b1;
              end else begin
                operand <= addend;
                work    <= total;
                idx     <= '0;
                carry   <= 1'b0;
                ready   <= 1'b0;
                state   <= ST_ADD;
              end
            end else if (buy_valid) begin
              if (price_bad) begin
                buy_fail <= 1'b1;
              end else begin
                operand <= price;
                work    <= total;
                idx     <= '0;
                carry   <= 1'b0;
                ready   <= 1'b0;
                state   <= ST_SUB;
              end
            end
          end
          ST_ADD, ST_SUB: begin
            work  <= work_next;
            carry <= res_cout;
            idx   <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state <= ST_COMMIT;
              if (!res_cout) begin
                total <= work_next;
                if (is_sub) buy_ok <= 1'b1;
                else        coin_accept <= 1'b1;
              end else begin
                if (is_sub) buy_fail <= 1'b1;
                else        coin_reject <= 1'b1;
              end
            end
          end
          ST_COMMIT: begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_money_accumulator_bcd.sv
// Directed bench for the BCD credit accumulator (DIGITS=4).
module tb_money_accumulator_bcd;

  logic        clk;
  logic        rst_n;
  logic [2:0]  coin;
  logic        coin_valid;
  logic [15:0] price;
  logic        buy_valid;
  logic        clear;
  logic        ready;
  logic [15:0] total;
  logic        coin_accept;
  logic        coin_reject;
  logic        buy_ok;
  logic        buy_fail;

  int vectors;
  int miscompares;

  localparam logic [3:0] P_ACC  = 4'b1000;
  localparam logic [3:0] P_REJ  = 4'b0100;
  localparam logic [3:0] P_OK   = 4'b0010;
  localparam logic [3:0] P_FAIL = 4'b0001;

  money_accumulator_bcd #(.DIGITS(4), .COIN_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin        (coin),
    .coin_valid  (coin_valid),
    .price       (price),
    .buy_valid   (buy_valid),
    .clear       (clear),
    .ready       (ready),
    .total       (total),
    .coin_accept (coin_accept),
    .coin_reject (coin_reject),
    .buy_ok      (buy_ok),
    .buy_fail    (buy_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one strobe in the current cycle and watch until ready returns (bounded).
  task automatic run_op(input logic cv, input logic [2:0] cd, input logic bv,
                        input logic [15:0] pr, output logic [3:0] which,
                        output int pcyc, output int npulse, output int rlow);
    logic [3:0] p;
    coin_valid = cv; coin = cd; buy_valid = bv; price = pr;
    which = 4'b0; pcyc = -1; npulse = 0; rlow = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin coin_valid = 1'b0; buy_valid = 1'b0; end
      p = {coin_accept, coin_reject, buy_ok, buy_fail};
      npulse += $countones(p);
      if (p != 4'b0 && pcyc < 0) begin pcyc = c; which = p; end
      if (!ready) rlow++;
      else break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; coin = 3'b0; coin_valid = 1'b0; price = 16'h0; buy_valid = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (total !== 16'h0000) begin miscompares++; $display("FAIL reset_total got=%h exp=0000", total); end
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", ready); end
    vectors++;
    if ({coin_accept, coin_reject, buy_ok, buy_fail} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_pulses got=%b exp=0000", {coin_accept, coin_reject, buy_ok, buy_fail});
    end
  endtask

  task automatic test_coins;
    logic [2:0] codes [3] = '{3'b100, 3'b100, 3'b000};
    logic [15:0] exp_tot [3] = '{16'h0050, 16'h0100, 16'h0105};
    logic [3:0] w; int pc, np, rl;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, codes[i], 1'b0, 16'h0, w, pc, np, rl);
      vectors++;
      if (w !== P_ACC || pc != 5 || np != 1) begin
        miscompares++; $display("FAIL coin%0d_pulse got=%b@%0d n=%0d exp=1000@5 n=1", i, w, pc, np);
      end
      vectors++;
      if (rl != 5) begin miscompares++; $display("FAIL coin%0d_ready_low got=%0d exp=5", i, rl); end
      vectors++;
      if (total !== exp_tot[i]) begin miscompares++; $display("FAIL coin%0d_total got=%h exp=%h", i, total, exp_tot[i]); end
    end
  endtask

  task automatic test_buy;
    logic [15:0] prices [3] = '{16'h0060, 16'h0050, 16'h0045};
    logic [3:0]  exp_p  [3] = '{P_OK, P_FAIL, P_OK};
    logic [15:0] exp_t  [3] = '{16'h0045, 16'h0045, 16'h0000};
    logic [3:0] w; int pc, np, rl;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, 3'b0, 1'b1, prices[i], w, pc, np, rl);
      vectors++;
      if (w !== exp_p[i] || pc != 5 || np != 1) begin
        miscompares++; $display("FAIL buy%0d_pulse got=%b@%0d n=%0d exp=%b@5 n=1", i, w, pc, np, exp_p[i]);
      end
      vectors++;
      if (total !== exp_t[i]) begin miscompares++; $display("FAIL buy%0d_total got=%h exp=%h", i, total, exp_t[i]); end
    end
  endtask

  task automatic test_ripple;
    logic [2:0] codes [8] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b101, 3'b100, 3'b011, 3'b011};
    logic [3:0] w; int pc, np, rl;
    for (int i = 0; i < 8; i++) run_op(1'b1, codes[i], 1'b0, 16'h0, w, pc, np, rl);
    run_op(1'b1, 3'b000, 1'b0, 16'h0, w, pc, np, rl);
    vectors++;
    if (total !== 16'h0995) begin miscompares++; $display("FAIL ripple_pre got=%h exp=0995", total); end
    run_op(1'b1, 3'b000, 1'b0, 16'h0, w, pc, np, rl);
    vectors++;
    if (w !== P_ACC || total !== 16'h1000) begin
      miscompares++; $display("FAIL ripple_carry got=%b/%h exp=1000/1000", w, total);
    end
  endtask

  task automatic test_coin_priority;
    logic [3:0] w; int pc, np, rl;
    run_op(1'b1, 3'b000, 1'b1, 16'h0001, w, pc, np, rl);
    vectors++;
    if (w !== P_ACC || np != 1 || total !== 16'h1005) begin
      miscompares++; $display("FAIL coin_priority got=%b n=%0d total=%h exp=1000 n=1 total=1005", w, np, total);
    end
    run_op(1'b0, 3'b0, 1'b1, 16'h00A0, w, pc, np, rl);
    vectors++;
    if (w !== P_FAIL || pc != 1 || rl != 0 || total !== 16'h1005) begin
      miscompares++; $display("FAIL bad_price got=%b@%0d rl=%0d total=%h exp=0001@1 rl=0 total=1005", w, pc, rl, total);
    end
  endtask

  task automatic test_clear;
    logic [3:0] w; int pc, np, rl; int seen;
    seen = 0;
    coin = 3'b100; coin_valid = 1'b1;
    @(posedge clk); #1;  // T+1
    coin_valid = 1'b0;
    seen += $countones({coin_accept, coin_reject, buy_ok, buy_fail});
    @(posedge clk); #1;  // T+2
    clear = 1'b1; coin = 3'b000; coin_valid = 1'b1;
    seen += $countones({coin_accept, coin_reject, buy_ok, buy_fail});
    @(posedge clk); #1;  // T+3
    clear = 1'b0; coin_valid = 1'b0;
    vectors++;
    if (total !== 16'h0000 || ready !== 1'b1) begin
      miscompares++; $display("FAIL clear_state got total=%h ready=%b exp=0000/1", total, ready);
    end
    for (int c = 0; c < 6; c++) begin
      seen += $countones({coin_accept, coin_reject, buy_ok, buy_fail});
      @(posedge clk); #1;
    end
    vectors++;
    if (seen != 0 || total !== 16'h0000) begin
      miscompares++; $display("FAIL clear_no_pulse got pulses=%0d total=%h exp=0/0000", seen, total);
    end
    run_op(1'b1, 3'b111, 1'b0, 16'h0, w, pc, np, rl);
    vectors++;
    if (w !== P_REJ || pc != 1 || rl != 0 || total !== 16'h0000) begin
      miscompares++; $display("FAIL invalid_coin got=%b@%0d rl=%0d total=%h exp=0100@1 rl=0 total=0000", w, pc, rl, total);
    end
  endtask

  task automatic test_overflow;
    logic [2:0] codes [5] = '{3'b101, 3'b100, 3'b011, 3'b011, 3'b000};
    logic [3:0] w; int pc, np, rl; int bad;
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      run_op(1'b1, 3'b110, 1'b0, 16'h0, w, pc, np, rl);
      if (w !== P_ACC) bad++;
    end
    vectors++;
    if (bad != 0 || total !== 16'h9800) begin
      miscompares++; $display("FAIL fill_9800 got rejects=%0d total=%h exp=0/9800", bad, total);
    end
    for (int i = 0; i < 5; i++) run_op(1'b1, codes[i], 1'b0, 16'h0, w, pc, np, rl);
    vectors++;
    if (total !== 16'h9995) begin miscompares++; $display("FAIL fill_9995 got=%h exp=9995", total); end
    run_op(1'b1, 3'b110, 1'b0, 16'h0, w, pc, np, rl);
    vectors++;
    if (w !== P_REJ || pc != 5 || np != 1 || total !== 16'h9995) begin
      miscompares++; $display("FAIL overflow got=%b@%0d n=%0d total=%h exp=0100@5 n=1 total=9995", w, pc, np, total);
    end
  endtask

  task automatic test_reset_mid_add;
    coin = 3'b000; coin_valid = 1'b1;
    @(posedge clk); #1;
    coin_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (total !== 16'h0000 || ready !== 1'b1) begin
      miscompares++; $display("FAIL async_reset got total=%h ready=%b exp=0000/1", total, ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (total !== 16'h0000 || ready !== 1'b1 || {coin_accept, coin_reject, buy_ok, buy_fail} !== 4'b0) begin
      miscompares++; $display("FAIL post_reset got total=%h ready=%b", total, ready);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_coins();
    test_buy();
    test_ripple();
    test_coin_priority();
    test_clear();
    test_overflow();
    test_reset_mid_add();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
